// File: rtl/riscv_pkg.sv
// riscv_pkg: result-source and load funct3 encodings shared by the write-back stage.
// Revision 1.0
`default_nettype none

package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/load_ext.sv
// load_ext: combinational load-data formatter (byte/half select and sign/zero extension).
// Revision 1.0
`default_nettype none

module load_ext
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    case (offset)
      2'd0: byte_sel = data[7:0];
      2'd1: byte_sel = data[15:8];
      2'd2: byte_sel = data[23:16];
      2'd3: byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
    // Half-word alignment is the caller's concern; offset[0] is deliberately ignored.
    half_sel = offset[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    result = data;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: MEM/WB pipeline register, result select and retire counter.
// Revision 1.0 -- load formatting enabled by macro WB_LOAD_EXT_EN.
`default_nettype none

module wb_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_m,
  input  logic             stall_w,
  input  logic             flush_w,
  input  logic [1:0]       result_src_m,
  input  logic [2:0]       funct3_m,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus4_m,
  input  logic [XLEN-1:0]  imm_m,
  output logic [XLEN-1:0]  result_w,
  output logic [4:0]       rd_w,
  output logic             reg_write_w,
  output logic             valid_w,
  output logic [CNT_W-1:0] retire_cnt
);

  logic            valid_q;
  logic            reg_write_q;
  logic [4:0]      rd_q;
  logic [1:0]      src_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      ld_funct3;
  logic [XLEN-1:0] load_val;

  // Flush wins over stall; a flush only kills the entry, data fields keep their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      src_q       <= RES_ALU;
      alu_q       <= '0;
      rdata_q     <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      retire_cnt  <= '0;
    end else if (flush_w) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall_w) begin
      valid_q     <= valid_m;
      reg_write_q <= reg_write_m;
      rd_q        <= rd_m;
      src_q       <= result_src_m;
      alu_q       <= alu_result_m;
      rdata_q     <= read_data_m;
      pc4_q       <= pc_plus4_m;
      imm_q       <= imm_m;
      if (valid_m) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] funct3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q <= '0;
    end else if (!flush_w && !stall_w) begin
      funct3_q <= funct3_m;
    end
  end

  assign ld_funct3 = funct3_q;
`else
  logic unused_funct3;

  // Word encoding makes the formatter a pass-through.
  assign unused_funct3 = ^funct3_m;
  assign ld_funct3     = F3_LW;
`endif

  load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .data   (rdata_q),
    .offset (alu_q[1:0]),
    .funct3 (ld_funct3),
    .result (load_val)
  );

  always_comb begin
    result_w = alu_q;
    if (int'(src_q) < NSRC) begin
      case (src_q)
        RES_MEM: result_w = load_val;
        RES_PC4: result_w = pc4_q;
        RES_IMM: result_w = imm_q;
        default: result_w = alu_q;
      endcase
    end
  end

  assign rd_w        = rd_q;
  assign valid_w     = valid_q;
  assign reg_write_w = valid_q & reg_write_q & (rd_q != 5'd0);

endmodule

`default_nettype wire

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter NSRC, default 4, legal 2..4: number of result sources.
REQ-003 SHALL have parameter CNT_W, default 32: width of the retire counter.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; rising-edge only.
- rst  in  1  asynchronous, active-high reset.
- valid_m  in  1  a MEM-stage instruction is present.
- stall_w  in  1  hold the WB register.
- flush_w  in  1  kill the entry being captured.
- result_src_m  in  2  source select: 0 ALU, 1 load data, 2 PC+4, 3 immediate.
- funct3_m  in  3  load type.
- reg_write_m  in  1  instruction writes rd.
- rd_m  in  5  destination register.
- alu_result_m, read_data_m, pc_plus4_m, imm_m  in  XLEN each  candidate results.
- result_w  out  XLEN  write-back data.
- rd_w  out  5  destination register.
- reg_write_w  out  1  qualified register-file write enable.
- valid_w  out  1  WB stage holds a valid instruction.
- retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-005 SHALL register all M-side inputs into a MEM/WB register on the rising clk edge; latency is exactly 1 cycle from capture to outputs.
REQ-006 SHALL apply flush_w before stall_w: flush_w=1 clears valid_w next cycle whatever stall_w is.
REQ-007 SHALL, with stall_w=1 and flush_w=0, hold every register (including valid_w) unchanged.
REQ-008 SHALL compute result_w combinationally from the registered fields, selected by result_src.
REQ-009 SHALL select alu_result for any result_src value >= NSRC.
REQ-010 SHALL drive reg_write_w = valid_w & reg_write & (rd_w != 0); writes to x0 are always suppressed.
REQ-011 SHALL increment retire_cnt by 1 on each edge that captures an entry with valid_m=1, stall_w=0, flush_w=0.
REQ-012 SHALL let retire_cnt wrap from all-ones to 0 with no flag.
REQ-013 SHALL take the load byte offset from registered alu_result[1:0].
REQ-014 SHALL, with extension enabled, format load data by funct3:
- 000 LB: sign-extend the byte at offset.
- 100 LBU: zero-extend the byte at offset.
- 001 LH: sign-extend the half selected by offset[1].
- 101 LHU: zero-extend the half selected by offset[1].
- any other value: pass the full word.
REQ-015 SHALL ignore offset[0] for half-word loads; misalignment is not detected in this block.

Reset
REQ-016 SHALL, while rst=1, asynchronously force valid_w=0, reg_write_w=0, rd_w=0, result_w=0 and retire_cnt=0; all stored fields also clear.
REQ-017 SHALL abandon any entry captured or held mid-stall when rst asserts.
REQ-018 SHALL capture normally on the first rising edge after rst deasserts.

Configuration
REQ-019 SHALL honour macro WB_LOAD_EXT_EN.
REQ-020 SHALL, when WB_LOAD_EXT_EN is defined, apply REQ-014 load formatting.
REQ-021 SHALL, when WB_LOAD_EXT_EN is undefined, pass read_data unmodified for source 1 and leave funct3_m unused.

Structure
REQ-022 SHALL place result-source encodings (RES_ALU=0, RES_MEM=1, RES_PC4=2, RES_IMM=3) and funct3 load encodings in shared package riscv_pkg.
REQ-023 SHALL implement load formatting as combinational sub-module load_ext (inputs: data, offset, funct3; output: XLEN result).
REQ-024 SHALL contain no other sub-modules.

Verification
REQ-025 SHALL cover: src=0, alu=0x0000_1234, valid=1, rd=5, reg_write=1 -> next cycle result_w=0x0000_1234, reg_write_w=1, retire_cnt=1.
REQ-026 SHALL cover: src=1, read_data=0x80FF_7F01, alu[1:0]=2, funct3=000 -> result_w=0xFFFF_FFFF; funct3=101 -> 0x0000_80FF; with macro undefined -> 0x80FF_7F01.
REQ-027 SHALL cover: a valid entry with stall_w=1 held 3 cycles -> outputs and retire_cnt unchanged; stall_w=1 with flush_w=1 together -> valid_w=0, reg_write_w=0, no increment.
REQ-028 SHALL cover: rd_m=0, reg_write_m=1, valid -> reg_write_w=0 while retire_cnt still increments.
REQ-029 SHALL cover: retire_cnt preloaded to all-ones via capture sequence (CNT_W=4, 16 captures) -> wraps to 0.
REQ-030 SHALL cover: rst asserted mid-cycle between edges -> all outputs 0 immediately without a clock edge.
REQ-031 SHALL cover: with NSRC=2 and src=3 -> result_w equals alu_result.
